// File: rtl/alu.sv
// Registered WIDTH-bit ALU (ADD/SUB/AND/OR/NOT, plus XOR/SHL/SHR when ALU_EXT_OPS_EN is defined).
// Latency: one cycle from in_valid to out_valid; back-to-back issue with no bubbles.
// Backpressure: none; every accepted operation produces a result the following cycle.
module alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_Sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             carry_out,
    output logic             zero,
    output logic             out_valid
);

    typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] dat;
    } res_t;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    res_t           res_nxt;

    // Extra top bit of the widened subtraction is the borrow (set when A < B).
    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        res_nxt = '0;
        case (ALU_Sel)
            3'b000: res_nxt = '{carry: sum[WIDTH],  dat: sum[WIDTH-1:0]};
            3'b001: res_nxt = '{carry: diff[WIDTH], dat: diff[WIDTH-1:0]};
            3'b010: res_nxt.dat = A & B;
            3'b011: res_nxt.dat = A | B;
            3'b100: res_nxt.dat = ~A;
`ifdef ALU_EXT_OPS_EN
            3'b101: res_nxt.dat = A ^ B;
            3'b110: res_nxt.dat = {A[WIDTH-2:0], 1'b0};
            3'b111: res_nxt.dat = {1'b0, A[WIDTH-1:1]};
`endif
            default: res_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_Out   <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                ALU_Out   <= res_nxt.dat;
                carry_out <= res_nxt.carry;
                zero      <= (res_nxt.dat == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table followed by randomized traffic against a reference model.
module tb_alu;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [2:0]   sel;
    logic         vld;
    logic [W-1:0] alu_out;
    logic         c_out;
    logic         z_out;
    logic         v_out;

    int total = 0;
    int bad   = 0;

    alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (a_in),
        .B         (b_in),
        .ALU_Sel   (sel),
        .in_valid  (vld),
        .ALU_Out   (alu_out),
        .carry_out (c_out),
        .zero      (z_out),
        .out_valid (v_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         r;
        logic         v;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   s;
        logic [W-1:0] eo;
        logic         ec;
        logic         ez;
        logic         ev;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int r, v, a, b, s, eo, ec, ez, ev);
        vec_t t;
        t.r = r[0]; t.v = v[0]; t.a = a[W-1:0]; t.b = b[W-1:0]; t.s = s[2:0];
        t.eo = eo[W-1:0]; t.ec = ec[0]; t.ez = ez[0]; t.ev = ev[0];
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] s);
        rst = r; vld = v; a_in = a; b_in = b; sel = s;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic modulo 2**W.
    function automatic void ref_op(input int a, input int b, input int s,
                                   output int res, output int cy);
        int m;
        m   = 1 << W;
        res = 0;
        cy  = 0;
        case (s)
            0: begin res = (a + b) % m; cy = (a + b >= m) ? 1 : 0; end
            1: begin res = (a - b + m) % m; cy = (a < b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = (m - 1) - a;
`ifdef ALU_EXT_OPS_EN
            5: res = a ^ b;
            6: res = (a * 2) % m;
            7: res = a / 2;
`endif
            default: res = 0;
        endcase
    endfunction

    initial begin
        int m_out, m_c, m_z, m_v, r, c;
        logic [W-1:0] ra, rb;
        logic [2:0] rs;
        logic rr, rv;

        // rst, vld, A, B, sel -> out, carry, zero, out_valid
        vecs.push_back(mk(1, 1,  3,  1, 0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1,  3,  1, 0,  4, 0, 0, 1));
        vecs.push_back(mk(0, 1,  4,  1, 1,  3, 0, 0, 1));
        vecs.push_back(mk(0, 1,  0,  1, 1, 15, 1, 0, 1));
        vecs.push_back(mk(0, 1, 12, 10, 2,  8, 0, 0, 1));
        vecs.push_back(mk(0, 1, 12, 10, 3, 14, 0, 0, 1));
        vecs.push_back(mk(0, 1, 10,  3, 4,  5, 0, 0, 1));
`ifdef ALU_EXT_OPS_EN
        vecs.push_back(mk(0, 1, 10,  3, 7,  5, 0, 0, 1));
`else
        vecs.push_back(mk(0, 1, 10,  3, 7,  0, 0, 1, 1));
`endif
        vecs.push_back(mk(0, 1, 15,  1, 0,  0, 1, 1, 1));
        vecs.push_back(mk(0, 0,  6,  7, 3,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0,  9,  2, 4,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0,  1,  1, 1,  0, 1, 1, 0));
        vecs.push_back(mk(0, 1,  9,  8, 0,  1, 1, 0, 1));
        vecs.push_back(mk(1, 1,  7,  7, 0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 0,  7,  7, 0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1,  5,  5, 1,  0, 0, 1, 1));
        vecs.push_back(mk(0, 1,  6,  9, 1, 13, 1, 0, 1));
        vecs.push_back(mk(0, 1,  2,  9, 0, 11, 0, 0, 1));
        vecs.push_back(mk(1, 1,  1,  1, 0,  0, 0, 1, 0));
`ifdef ALU_EXT_OPS_EN
        vecs.push_back(mk(0, 1, 12, 10, 5,  6, 0, 0, 1));
        vecs.push_back(mk(0, 1,  9,  0, 6,  2, 0, 0, 1));
        vecs.push_back(mk(0, 1,  8,  0, 6,  0, 0, 1, 1));
`else
        vecs.push_back(mk(0, 1, 12, 10, 5,  0, 0, 1, 1));
        vecs.push_back(mk(0, 1,  9,  0, 6,  0, 0, 1, 1));
        vecs.push_back(mk(0, 1,  8,  0, 6,  0, 0, 1, 1));
`endif

        rst = 1'b1; vld = 1'b0; a_in = '0; b_in = '0; sel = '0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].s);
            check($sformatf("vec%0d_out", i),   alu_out, vecs[i].eo);
            check($sformatf("vec%0d_carry", i), c_out,   vecs[i].ec);
            check($sformatf("vec%0d_zero", i),  z_out,   vecs[i].ez);
            check($sformatf("vec%0d_valid", i), v_out,   vecs[i].ev);
        end

        // Randomized traffic; model restarts from a reset cycle.
        cycle(1'b1, 1'b0, '0, '0, '0);
        m_out = 0; m_c = 0; m_z = 1; m_v = 0;
        for (int n = 0; n < 400; n++) begin
            rr = ($urandom_range(0, 24) == 0);
            rv = ($urandom_range(0, 3) != 0);
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 3'($urandom);
            cycle(rr, rv, ra, rb, rs);
            if (rr) begin
                m_out = 0; m_c = 0; m_z = 1; m_v = 0;
            end else begin
                m_v = rv;
                if (rv) begin
                    ref_op(ra, rb, rs, r, c);
                    m_out = r; m_c = c; m_z = (r == 0) ? 1 : 0;
                end
            end
            check($sformatf("rnd%0d_out", n),   alu_out, m_out);
            check($sformatf("rnd%0d_carry", n), c_out,   m_c);
            check($sformatf("rnd%0d_zero", n),  z_out,   m_z);
            check($sformatf("rnd%0d_valid", n), v_out,   m_v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
